// File: rtl/led_shift_driver.sv
// -----------------------------------------------------------------------------
// led_shift_driver
//
// Serialises a parallel LED pattern into a 74HC595-style shift/latch driver.
// A frame is WIDTH bits shifted MSB first, followed by a latch strobe. A frame
// starts once after reset, whenever LED differs from the last pattern sent, and
// optionally when an unchanged pattern has sat idle for REFRESH_CYCLES cycles.
// LED is sampled only while idle, so changes during a frame coalesce and only
// the newest value is sent next.
//
// Parameters:
//   WIDTH          bits per frame
//   CLK_DIV        clk cycles per sclk half-period and latch pulse (1..255)
//   REFRESH_CYCLES idle cycles before an unchanged pattern is re-sent (0 = off)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset; aborts a frame without latch
//   LED        in   parallel pattern (WIDTH bits)
//   sdo        out  serial data, valid around each sclk rising edge
//   sclk       out  shift clock; chip samples sdo on its rising edge
//   latch      out  storage-register strobe, active-high
//   busy       out  high while a frame is in progress
//   frame_done out  one-cycle pulse on the final latch cycle
// -----------------------------------------------------------------------------
module led_shift_driver #(
  parameter int WIDTH          = 16,
  parameter int CLK_DIV        = 2,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] LED,
  output logic             sdo,
  output logic             sclk,
  output logic             latch,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [BW-1:0] LAST_BIT     = BW'(WIDTH - 1);
  localparam logic [7:0]    DIV_LAST     = 8'(CLK_DIV - 1);
  // frame_done must already be high on the last latch cycle, so it is raised
  // one divider step early; with a one-cycle latch it is raised on entry.
  localparam logic [7:0]    DIV_DONE     = 8'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic          DONE_ON_ENTRY = (CLK_DIV == 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_last_sent;
  logic             r_init_pending;
  logic [RW-1:0]    r_refresh_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [7:0]       r_div;
  logic             r_sdo;
  logic             r_sclk;
  logic             r_latch;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_refresh_due;
  logic             w_pending;
  logic [WIDTH-1:0] w_next_shreg;

  assign w_refresh_due = (REFRESH_CYCLES != 0) && (r_refresh_cnt == REFRESH_LAST);
  assign w_pending     = r_init_pending || (LED != r_last_sent) || w_refresh_due;
  assign w_next_shreg  = r_shreg << 1;

  // NOTE: reset is synchronous, so rst_n is tested inside the clocked block and
  // deliberately left out of the sensitivity list; all state uses <= so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_shreg        <= '0;
      r_last_sent    <= '0;
      r_init_pending <= 1'b1;
      r_refresh_cnt  <= '0;
      r_bit_cnt      <= '0;
      r_div          <= '0;
      r_sdo          <= 1'b0;
      r_sclk         <= 1'b0;
      r_latch        <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_shreg        <= LED;
            r_last_sent    <= LED;
            r_init_pending <= 1'b0;
            r_refresh_cnt  <= '0;
            r_bit_cnt      <= '0;
            r_div          <= '0;
            r_sdo          <= LED[WIDTH-1];
            r_busy         <= 1'b1;
            r_state        <= ST_SHIFT_LO;
          end else if (r_refresh_cnt != REFRESH_LAST) begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
          end
        end

        ST_SHIFT_LO: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_sclk  <= 1'b1;
            r_state <= ST_SHIFT_HI;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        ST_SHIFT_HI: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            // sdo only moves on the falling sclk edge, keeping it stable for a
            // full period around the chip's sampling edge.
            if (r_bit_cnt == LAST_BIT) begin
              r_sdo        <= 1'b0;
              r_latch      <= 1'b1;
              r_frame_done <= DONE_ON_ENTRY;
              r_state      <= ST_LATCH;
            end else begin
              r_shreg   <= w_next_shreg;
              r_sdo     <= w_next_shreg[WIDTH-1];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_state   <= ST_SHIFT_LO;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        ST_LATCH: begin
          if (r_div == DIV_LAST) begin
            r_div        <= '0;
            r_latch      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_div        <= r_div + 1'b1;
            r_frame_done <= (r_div == DIV_DONE);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sdo        = r_sdo;
  assign sclk       = r_sclk;
  assign latch      = r_latch;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_shift_driver.sv
// -----------------------------------------------------------------------------
// tb_led_shift_driver
//
// Two instances: dut0 uses the defaults (CLK_DIV=2, no refresh), dut1 uses
// CLK_DIV=1 with REFRESH_CYCLES=10. A monitor watches each instance's pins the
// way the external chip would (bits captured on sclk rising edges, latch and
// busy lengths, frame_done placement, idle gap before a frame) and logs one
// record per frame. Directed steps with random patterns compare those records
// against frames predicted from the LED values the bench drove.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_shift_driver;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n0, rst_n1;
  logic [W-1:0] led0, led1;
  logic [1:0]   sdo, sclk, latch, busy, fdone;

  led_shift_driver #(.WIDTH(W), .CLK_DIV(2), .REFRESH_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .LED(led0), .sdo(sdo[0]), .sclk(sclk[0]),
    .latch(latch[0]), .busy(busy[0]), .frame_done(fdone[0]));

  led_shift_driver #(.WIDTH(W), .CLK_DIV(1), .REFRESH_CYCLES(10)) dut1 (
    .clk(clk), .rst_n(rst_n1), .LED(led1), .sdo(sdo[1]), .sclk(sclk[1]),
    .latch(latch[1]), .busy(busy[1]), .frame_done(fdone[1]));

  typedef struct {
    logic [W-1:0] bits;
    int nbits;
    int busy_len;
    int latch_len;
    int latch_pulses;
    int fd_cycles;
    int fd_pos;
    int gap;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------- monitor
  logic [W-1:0] m_bits[2];
  int   m_nbits[2], m_busy_len[2], m_latch_len[2], m_pulses[2];
  int   m_fd[2], m_fd_pos[2], m_gap[2], m_idle[2];
  logic m_prev_sclk[2], m_prev_latch[2], m_prev_busy[2], m_prev_sdo[2];
  int   idle_glitch[2], sdo_glitch[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_bits[k] = '0; m_nbits[k] = 0; m_busy_len[k] = 0; m_latch_len[k] = 0;
      m_pulses[k] = 0; m_fd[k] = 0; m_fd_pos[k] = 0; m_gap[k] = 0; m_idle[k] = 0;
      m_prev_sclk[k] = 1'b0; m_prev_latch[k] = 1'b0; m_prev_busy[k] = 1'b0;
      m_prev_sdo[k] = 1'b0; idle_glitch[k] = 0; sdo_glitch[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (busy[k] === 1'b1) begin
        if (m_prev_busy[k] !== 1'b1) begin
          m_bits[k] = '0; m_nbits[k] = 0; m_busy_len[k] = 0; m_latch_len[k] = 0;
          m_pulses[k] = 0; m_fd[k] = 0; m_fd_pos[k] = 0; m_gap[k] = m_idle[k];
        end
        m_busy_len[k]++;
        if (sclk[k] === 1'b1 && m_prev_sclk[k] !== 1'b1) begin
          m_bits[k] = {m_bits[k][W-2:0], sdo[k]};
          m_nbits[k]++;
        end
        if (sclk[k] === 1'b1 && m_prev_sclk[k] === 1'b1 && sdo[k] !== m_prev_sdo[k])
          sdo_glitch[k]++;
        if (latch[k] === 1'b1) begin
          m_latch_len[k]++;
          if (m_prev_latch[k] !== 1'b1) m_pulses[k]++;
        end
        if (fdone[k] === 1'b1) begin
          m_fd[k]++;
          m_fd_pos[k] = m_latch_len[k];
        end
      end else begin
        if (m_prev_busy[k] === 1'b1) begin
          frame_t f;
          f.bits = m_bits[k]; f.nbits = m_nbits[k]; f.busy_len = m_busy_len[k];
          f.latch_len = m_latch_len[k]; f.latch_pulses = m_pulses[k];
          f.fd_cycles = m_fd[k]; f.fd_pos = m_fd_pos[k]; f.gap = m_gap[k];
          if (k == 0) q0.push_back(f); else q1.push_back(f);
          m_idle[k] = 0;
        end
        m_idle[k]++;
        if (sclk[k] === 1'b1 || latch[k] === 1'b1 || fdone[k] === 1'b1)
          idle_glitch[k]++;
      end
      m_prev_sclk[k]  = sclk[k];
      m_prev_latch[k] = latch[k];
      m_prev_busy[k]  = busy[k];
      m_prev_sdo[k]   = sdo[k];
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic wait_frames(input int k, input int n, input int budget, input string tag);
    int c = 0;
    while (qsize(k) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, ".frame_arrived"}, 32'(qsize(k) >= n), 32'd1);
  endtask

  task automatic wait_busy(input int k, input int budget, input string tag);
    int c = 0;
    while (busy[k] !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, ".busy_seen"}, 32'(busy[k]), 32'd1);
  endtask

  // Expected frame: WIDTH bits equal to the pattern, busy for
  // 2*div*WIDTH + div cycles, one latch pulse of div cycles, and exactly one
  // frame_done on its final cycle. exp_gap < 0 skips the idle-gap check.
  task automatic check_frame(input int k, input string tag, input logic [W-1:0] exp_bits,
                             input int div, input int exp_gap);
    frame_t f;
    if (qsize(k) > 0) f = (k == 0) ? q0.pop_front() : q1.pop_front();
    else begin
      f.bits = 'x; f.nbits = -1; f.busy_len = -1; f.latch_len = -1;
      f.latch_pulses = -1; f.fd_cycles = -1; f.fd_pos = -1; f.gap = -1;
    end
    check({tag, ".bits"},     32'(f.bits),         32'(exp_bits));
    check({tag, ".nbits"},    32'(f.nbits),        32'(W));
    check({tag, ".busy_len"}, 32'(f.busy_len),     32'(2 * div * W + div));
    check({tag, ".latch_len"},32'(f.latch_len),    32'(div));
    check({tag, ".latch_pulses"}, 32'(f.latch_pulses), 32'd1);
    check({tag, ".frame_done"}, 32'(f.fd_cycles),  32'd1);
    check({tag, ".fd_on_last_latch"}, 32'(f.fd_pos), 32'(div));
    if (exp_gap >= 0) check({tag, ".idle_gap"}, 32'(f.gap), 32'(exp_gap));
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [W-1:0] last0, a, b, c, v;

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    led0 = 16'h0000; led1 = 16'hA5A5;
    repeat (3) @(negedge clk);
    check("reset.outs0", {27'b0, sdo[0], sclk[0], latch[0], busy[0], fdone[0]}, 32'd0);
    check("reset.outs1", {27'b0, sdo[1], sclk[1], latch[1], busy[1], fdone[1]}, 32'd0);
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    // One frame after reset even though LED equals the reset value of last_sent.
    wait_frames(0, 1, 200, "t1");
    check_frame(0, "t1.init", 16'h0000, 2, -1);
    repeat (50) @(negedge clk);
    check("t1.no_repeat", 32'(q0.size()), 32'd0);
    check("t1.busy_low", 32'(busy[0]), 32'd0);

    led0 = 16'h001F;
    wait_frames(0, 1, 200, "t2");
    check_frame(0, "t2.001F", 16'h001F, 2, -1);
    last0 = 16'h001F;

    // Random patterns applied while idle.
    for (int i = 0; i < 4; i++) begin
      do v = 16'($urandom); while (v == last0);
      led0 = v;
      wait_frames(0, 1, 200, "t2r");
      check_frame(0, $sformatf("t2r%0d", i), v, 2, -1);
      last0 = v;
    end

    // Coalescing: b and c arrive mid-frame; only a and then c are sent,
    // c starting on the first idle cycle.
    do a = 16'($urandom); while (a == last0);
    do b = 16'($urandom); while (b == a);
    do c = 16'($urandom); while (c == a || c == b || c == 16'hFFFF);
    led0 = a;
    wait_busy(0, 20, "t3");
    repeat (10) @(negedge clk);
    led0 = b;
    repeat (10) @(negedge clk);
    led0 = c;
    wait_frames(0, 2, 400, "t3");
    check_frame(0, "t3.first", a, 2, -1);
    check_frame(0, "t3.newest", c, 2, 1);
    repeat (200) @(negedge clk);
    check("t3.no_extra", 32'(q0.size()), 32'd0);

    // Reset at bit 7 of an all-ones frame: abort with no latch, then resend.
    led0 = 16'hFFFF;
    wait_busy(0, 20, "t4");
    begin
      int cyc = 0;
      while (m_nbits[0] != 7 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("t4.reached_bit7", 32'(m_nbits[0]), 32'd7);
    end
    rst_n0 = 1'b0;
    @(negedge clk);
    check("t4.abort_outs", {29'b0, sclk[0], latch[0], busy[0]}, 32'd0);
    rst_n0 = 1'b1;
    wait_frames(0, 2, 300, "t4");
    begin
      frame_t f;
      if (q0.size() > 0) f = q0.pop_front();
      else begin f.nbits = -1; f.latch_len = -1; f.fd_cycles = -1; end
      check("t4.aborted.nbits", 32'(f.nbits), 32'd7);
      check("t4.aborted.latch", 32'(f.latch_len), 32'd0);
      check("t4.aborted.fd", 32'(f.fd_cycles), 32'd0);
    end
    check_frame(0, "t4.fresh", 16'hFFFF, 2, -1);

    // Refresh on dut1: constant pattern resent after exactly 10 idle cycles.
    q1.delete();
    wait_frames(1, 3, 300, "t5");
    for (int i = 0; i < 3; i++) check_frame(1, $sformatf("t5.refresh%0d", i), 16'hA5A5, 1, 10);
    do v = 16'($urandom); while (v == 16'hA5A5);
    led1 = v;
    repeat (60) @(negedge clk);
    q1.delete();
    wait_frames(1, 2, 300, "t5r");
    check_frame(1, "t5r.0", v, 1, 10);
    check_frame(1, "t5r.1", v, 1, 10);

    // No refresh on dut0: silence for 1000 cycles.
    repeat (1000) @(negedge clk);
    check("t6.no_frames", 32'(q0.size()), 32'd0);
    check("t6.outs_low", {29'b0, sclk[0], latch[0], busy[0]}, 32'd0);

    check("idle_activity0", 32'(idle_glitch[0]), 32'd0);
    check("idle_activity1", 32'(idle_glitch[1]), 32'd0);
    check("sdo_stable0", 32'(sdo_glitch[0]), 32'd0);
    check("sdo_stable1", 32'(sdo_glitch[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
